// File: rtl/spi_peripheral_pkg.sv
// spi_peripheral_pkg: state encoding and width constants shared by the SPI peripheral files.
package spi_peripheral_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 3;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_peripheral_sync.sv
// spi_peripheral_sync: two-flop synchronizer for one SPI pin, with an optional third stage for edge detection.
module spi_peripheral_sync
  import spi_peripheral_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter bit EDGE = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [1:0] s;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) s <= {2{RST_VAL}};
    else s <= {s[0], d};
  assign q = s[1];
  if (EDGE) begin : g_edge
    logic p;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) p <= RST_VAL;
      else p <= s[1];
    assign rise = s[1] & ~p;
    assign fall = ~s[1] & p;
  end else begin : g_level
    assign rise = 1'b0;
    assign fall = 1'b0;
  end
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI peripheral with byte-wide rx/tx handshakes.
// Define SPI_PERIPHERAL_OVERRUN_EN to keep the old byte on overrun and flag it on rx_overrun.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              pico,
  input  logic              cs,
  output logic              poci,
  output logic              poci_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  ,
  output logic              rx_overrun,
  input  logic              rx_overrun_clear
`endif
);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, pico_s, pico_rise, pico_fall;
  spi_peripheral_sync #(.RST_VAL(CPOL), .EDGE(1'b1)) u_sclk (
    .clock(clock), .reset_n(reset_n), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_peripheral_sync #(.RST_VAL(1'b1), .EDGE(1'b1)) u_cs (
    .clock(clock), .reset_n(reset_n), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_peripheral_sync #(.RST_VAL(1'b0), .EDGE(1'b0)) u_pico (
    .clock(clock), .reset_n(reset_n), .d(pico), .q(pico_s), .rise(pico_rise), .fall(pico_fall)
  );
  logic unused_sync;
  assign unused_sync = ^{sclk_s, pico_rise, pico_fall};
  state_t state, state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0] tx_sr, rx_sr, tx_hold, rx_byte;
  logic [1:0] flush;
  logic tx_full, armed, start, lead, trail, sample, shift, byte_done, load, tx_take;
  // A cs already low when reset releases must not start a transfer: arm only after cs is seen high.
  always_comb begin
    start = (state == IDLE) && cs_fall && armed;
    lead = CPOL ? sclk_fall : sclk_rise;
    trail = CPOL ? sclk_rise : sclk_fall;
    sample = (state == ACTIVE) && (CPHA ? trail : lead);
    shift = (state == ACTIVE) && (CPHA ? lead : trail) && (bit_cnt != '0);
    byte_done = sample && (bit_cnt == CNT_W'(BYTE_W - 1));
    load = start || byte_done;
    state_n = (state == IDLE) ? (start ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
  end
  assign tx_ready = !tx_full;
  assign tx_take = tx_valid && tx_ready;
  assign rx_byte = {rx_sr[BYTE_W-2:0], pico_s};
  assign busy = (state == ACTIVE);
  assign poci_oe = busy;
  assign poci = busy & tx_sr[BYTE_W-1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // The first shift edge after a load is skipped so the freshly loaded MSB is not lost.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bit_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      tx_hold <= '0;
      tx_full <= 1'b0;
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[0], 1'b1};
      armed <= armed | (flush[1] & cs_s);
      bit_cnt <= load ? '0 : sample ? bit_cnt + 1'b1 : bit_cnt;
      rx_sr <= sample ? rx_byte : rx_sr;
      tx_sr <= load ? (tx_full ? tx_hold : tx_take ? tx_data : IDLE_BYTE)
             : shift ? {tx_sr[BYTE_W-2:0], 1'b0} : tx_sr;
      tx_hold <= tx_take ? tx_data : tx_hold;
      tx_full <= load ? 1'b0 : tx_take ? 1'b1 : tx_full;
    end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic overrun, rx_accept;
  assign overrun = byte_done && rx_valid && !rx_ready;
  assign rx_accept = byte_done && !overrun;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_data <= rx_accept ? rx_byte : rx_data;
      rx_valid <= rx_accept || (rx_valid && !rx_ready);
      rx_overrun <= overrun || (rx_overrun && !rx_overrun_clear);
    end
`else
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_data <= byte_done ? rx_byte : rx_data;
      rx_valid <= byte_done || (rx_valid && !rx_ready);
    end
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: mode-0 and mode-3 instances driven by a bit-banged SPI controller with rx/tx scoreboards.
module tb_spi_peripheral;
  localparam int H = 40;
  logic clock, reset_n, pico;
  logic [1:0] sclk, cs, poci, poci_oe, rx_valid, rx_ready, tx_valid, tx_ready, busy;
  logic [1:0][7:0] rx_data, tx_data;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic [1:0] rx_overrun, rx_overrun_clear;
`endif
  logic [7:0] mosi_q[$], miso_q[$], exp_tx[$], exp_rx[$], got_q[$];
  int checks = 0, errors = 0;

  spi_peripheral dut0 (
    .clock(clock), .reset_n(reset_n), .sclk(sclk[0]), .pico(pico), .cs(cs[0]),
    .poci(poci[0]), .poci_oe(poci_oe[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0])
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    , .rx_overrun(rx_overrun[0]), .rx_overrun_clear(rx_overrun_clear[0])
`endif
  );
  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clock(clock), .reset_n(reset_n), .sclk(sclk[1]), .pico(pico), .cs(cs[1]),
    .poci(poci[1]), .poci_oe(poci_oe[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1])
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    , .rx_overrun(rx_overrun[1]), .rx_overrun_clear(rx_overrun_clear[1])
`endif
  );

  always #5 clock = ~clock;

  // rx handshake monitor: sampled mid-cycle, the handshake completes on the following rising edge
  always @(negedge clock) begin
    if (rx_valid[0] && rx_ready[0]) got_q.push_back(rx_data[0]);
    if (rx_valid[1] && rx_ready[1]) got_q.push_back(rx_data[1]);
  end

  task automatic send_tx(input int m, input logic [7:0] d);
    int t = 0;
    @(negedge clock);
    tx_data[m] = d;
    tx_valid[m] = 1'b1;
    while (!tx_ready[m] && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL tx_ready_timeout tx_ready %b want 1", tx_ready[m]);
    end
    @(negedge clock);
    tx_valid[m] = 1'b0;
  endtask

  // m=0: CPOL0/CPHA0 controller, m=1: CPOL1/CPHA1 controller; entered on a falling clock edge
  task automatic spi_run(input int m, input int nbits, input bit raise);
    logic [7:0] b, r;
    b = 8'h00;
    r = 8'h00;
    cs[m] = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) b = mosi_q.pop_front();
      if (m == 0) begin
        pico = b[7 - (i % 8)];
        #(H);
        r[7 - (i % 8)] = poci[0];
        sclk[0] = 1'b1;
        #(H);
        sclk[0] = 1'b0;
      end else begin
        sclk[1] = 1'b0;
        pico = b[7 - (i % 8)];
        #(H);
        r[7 - (i % 8)] = poci[1];
        sclk[1] = 1'b1;
        #(H);
      end
      if (i % 8 == 7) miso_q.push_back(r);
    end
    if (raise) begin
      #(H);
      cs[m] = 1'b1;
      #(H);
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (busy[m] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", m, busy[m]); end
      checks++; if (poci[m] !== 1'b0) begin errors++; $display("FAIL reset_poci[%0d] got %b want 0", m, poci[m]); end
      checks++; if (poci_oe[m] !== 1'b0) begin errors++; $display("FAIL reset_poci_oe[%0d] got %b want 0", m, poci_oe[m]); end
      checks++; if (rx_valid[m] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid[%0d] got %b want 0", m, rx_valid[m]); end
      checks++; if (rx_data[m] !== 8'h00) begin errors++; $display("FAIL reset_rx_data[%0d] got %h want 00", m, rx_data[m]); end
      checks++; if (tx_ready[m] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready[%0d] got %b want 1", m, tx_ready[m]); end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
      checks++; if (rx_overrun[m] !== 1'b0) begin errors++; $display("FAIL reset_rx_overrun[%0d] got %b want 0", m, rx_overrun[m]); end
`endif
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_mode0;
    logic [7:0] e, g;
    send_tx(0, 8'hA5);
    mosi_q.push_back(8'h3C); exp_rx.push_back(8'h3C); exp_tx.push_back(8'hA5);
    spi_run(0, 8, 1'b1);
    repeat (4) @(negedge clock);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL mode0_rx got %h want %h", g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mode0_rx_count extra %0d want 0", got_q.size()); got_q.delete(); end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL mode0_poci got %h want %h", g, e); end
    end
  endtask

  task automatic test_mode3;
    logic [7:0] e, g;
    mosi_q.push_back(8'h81); exp_rx.push_back(8'h81); exp_tx.push_back(8'hFF);
    spi_run(1, 8, 1'b1);
    repeat (4) @(negedge clock);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL mode3_rx got %h want %h", g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mode3_rx_count extra %0d want 0", got_q.size()); got_q.delete(); end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL mode3_poci got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, g;
    send_tx(0, 8'h10);
    foreach (mosi_q[i]) mosi_q.delete(i);
    mosi_q.push_back(8'h01); mosi_q.push_back(8'h02); mosi_q.push_back(8'h03);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
    exp_tx.push_back(8'h10); exp_tx.push_back(8'h20); exp_tx.push_back(8'hFF);
    fork
      spi_run(0, 24, 1'b1);
      begin
        repeat (8) @(negedge clock);
        send_tx(0, 8'h20);
      end
    join
    repeat (4) @(negedge clock);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_rx got %h want %h", g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b_rx_count extra %0d want 0", got_q.size()); got_q.delete(); end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_poci got %h want %h", g, e); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] e, g;
    send_tx(0, 8'hAA);
    mosi_q.push_back(8'h13);
    spi_run(0, 5, 1'b1);
    repeat (10) @(negedge clock);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL abort_rx_valid count %0d want 0", got_q.size()); got_q.delete(); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_tx_ready got %b want 1", tx_ready[0]); end
    mosi_q.push_back(8'h55); exp_rx.push_back(8'h55); exp_tx.push_back(8'hFF);
    spi_run(0, 8, 1'b1);
    repeat (4) @(negedge clock);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL abort_next_rx got %h want %h", g, e); end
    end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL abort_next_poci got %h want %h", g, e); end
    end
  endtask

  task automatic test_overrun;
    logic [7:0] e, g, keep;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    keep = 8'hAA;
`else
    keep = 8'hBB;
`endif
    rx_ready[0] = 1'b0;
    mosi_q.push_back(8'hAA); mosi_q.push_back(8'hBB);
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    exp_rx.push_back(keep);
    spi_run(0, 16, 1'b1);
    repeat (4) @(negedge clock);
    checks++; if (rx_valid[0] !== 1'b1) begin errors++; $display("FAIL overrun_rx_valid got %b want 1", rx_valid[0]); end
    checks++; if (rx_data[0] !== keep) begin errors++; $display("FAIL overrun_rx_data got %h want %h", rx_data[0], keep); end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    checks++; if (rx_overrun[0] !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", rx_overrun[0]); end
`endif
    @(posedge clock);
    #2 rx_ready[0] = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL overrun_rx_valid_clear got %b want 0", rx_valid[0]); end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    checks++; if (rx_overrun[0] !== 1'b1) begin errors++; $display("FAIL overrun_flag_sticky got %b want 1", rx_overrun[0]); end
    rx_overrun_clear[0] = 1'b1;
    @(negedge clock);
    rx_overrun_clear[0] = 1'b0;
    @(negedge clock);
    checks++; if (rx_overrun[0] !== 1'b0) begin errors++; $display("FAIL overrun_flag_clear got %b want 0", rx_overrun[0]); end
`endif
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL overrun_rx got %h want %h", g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL overrun_rx_count extra %0d want 0", got_q.size()); got_q.delete(); end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL overrun_poci got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e, g;
    mosi_q.push_back(8'hF0);
    spi_run(0, 4, 1'b0);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy[0]); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy[0]); end
    checks++; if (poci_oe[0] !== 1'b0) begin errors++; $display("FAIL midreset_poci_oe got %b want 0", poci_oe[0]); end
    checks++; if (poci[0] !== 1'b0) begin errors++; $display("FAIL midreset_poci got %b want 0", poci[0]); end
    checks++; if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL midreset_rx_valid got %b want 0", rx_valid[0]); end
    checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL midreset_rx_data got %h want 00", rx_data[0]); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL midreset_tx_ready got %b want 1", tx_ready[0]); end
    #16 reset_n = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_stale_cs busy %b want 0", busy[0]); end
    cs[0] = 1'b1;
    repeat (8) @(negedge clock);
    mosi_q.push_back(8'hC3); exp_rx.push_back(8'hC3); exp_tx.push_back(8'hFF);
    spi_run(0, 8, 1'b1);
    repeat (4) @(negedge clock);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL midreset_next_rx got %h want %h", g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midreset_rx_count extra %0d want 0", got_q.size()); got_q.delete(); end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); g = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL midreset_next_poci got %h want %h", g, e); end
    end
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b1;
    pico = 1'b0;
    sclk = 2'b10;
    cs = 2'b11;
    rx_ready = 2'b11;
    tx_valid = 2'b00;
    tx_data = '0;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    rx_overrun_clear = 2'b00;
`endif
    test_reset;
    test_mode0;
    test_mode3;
    test_back_to_back;
    test_abort;
    test_overrun;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter CPOL, default 0, idle level of sclk.
REQ-002 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter IDLE_BYTE, default 8'hFF, the byte shifted out when no tx byte is pending.
REQ-004 SHALL have ports: clock  in  1  system clock; single clock domain.
REQ-005 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: sclk, pico, cs  in  1 each  SPI pins from the controller; cs is active-low; all asynchronous to clock.
REQ-007 SHALL have: poci  out  1  serial data to the controller; poci_oe  out  1  high while cs is asserted.
REQ-008 SHALL have: rx_data  out  8  received byte; rx_valid  out  1; rx_ready  in  1.
REQ-009 SHALL have: tx_data  in  8  byte to send; tx_valid  in  1; tx_ready  out  1.
REQ-010 SHALL have: busy  out  1  high while cs is asserted (synchronized).

Function
REQ-011 SHALL pass sclk, pico and cs through 2-flop synchronizers, plus one extra stage on sclk and cs for edge detection; correct operation requires a sclk half-period of at least 3 clock cycles.
REQ-012 SHALL use two states: IDLE (cs high) and ACTIVE (cs low); IDLE->ACTIVE on a synchronized cs fall; ACTIVE->IDLE on a synchronized cs rise.
REQ-013 On entering ACTIVE and at each byte boundary, SHALL load the shift register with the tx holding byte if it is full (and mark it empty), else with IDLE_BYTE; bit counter SHALL be reset to 0.
REQ-014 Leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite.
REQ-015 SHALL sample pico on the sample edge, MSB first; SHALL shift poci on the other edge; when CPHA=0, the MSB SHALL appear on poci at load, before the first sclk edge.
REQ-016 On the 8th sample, SHALL write the byte to rx_data and assert rx_valid on the next clock (at most 4 clocks after the pin edge); rx_valid SHALL hold until the clock on which rx_valid && rx_ready is true.
REQ-017 tx_ready SHALL be high when the tx holding register is empty; a tx_valid && tx_ready clock SHALL capture tx_data and drop tx_ready on the next clock.
REQ-018 Simultaneous tx capture and byte-boundary load SHALL load the captured byte directly, leaving the holding register empty.
REQ-019 cs deassert mid-byte SHALL discard the partial rx byte without asserting rx_valid; the loaded tx byte is consumed and not retransmitted.
REQ-020 A byte completing while rx_valid is high and rx_ready is low is an overrun, handled per REQ-025/026.
REQ-021 poci SHALL be 0 and poci_oe 0 in IDLE.

Reset
REQ-022 reset_n low SHALL immediately force: IDLE, rx_data=0, rx_valid=0, tx_ready=1, tx holding empty, poci=0, poci_oe=0, busy=0, bit counter 0.
REQ-023 Synchronizer flops SHALL reset to cs=1 and sclk=CPOL, so that no edge is detected on release.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer; after release the block SHALL wait for a fresh cs fall.

Configuration
REQ-025 With SPI_PERIPHERAL_OVERRUN_EN defined: port rx_overrun out 1 and port rx_overrun_clear in 1 SHALL exist; on overrun the old rx_data SHALL be kept, the new byte dropped, and rx_overrun set sticky until rx_overrun_clear or reset.
REQ-026 Without SPI_PERIPHERAL_OVERRUN_EN: neither port SHALL exist; on overrun the new byte SHALL overwrite rx_data and rx_valid SHALL stay high.

Structure
REQ-027 Package spi_peripheral_pkg SHALL hold the state encoding (IDLE, ACTIVE), bit-counter width (3) and byte width constant (8).
REQ-028 Synchronizer plus edge detector SHALL be sub-module spi_peripheral_sync, instantiated once per input pin.

Verification
REQ-029 Mode 0, clock/sclk = 8: preload tx 8'hA5; controller sends 8'h3C -> rx_data=8'h3C with one rx_valid, controller reads 8'hA5.
REQ-030 Mode 3, no tx preload: controller sends 8'h81 -> rx_data=8'h81, controller reads 8'hFF.
REQ-031 Three back-to-back bytes 8'h01, 8'h02, 8'h03 under one cs, tx preloaded 8'h10 then 8'h20 while tx_ready -> rx_valid three times in order; controller reads 8'h10, 8'h20, 8'hFF.
REQ-032 cs raised after 5 bits -> no rx_valid; next full byte 8'h55 is received correctly.
REQ-033 rx_ready held 0 across two bytes 8'hAA, 8'hBB -> with macro: rx_data=8'hAA and rx_overrun=1; without macro: rx_data=8'hBB.
REQ-034 reset_n pulsed low at bit 4 -> all outputs at reset values within the same cycle; the next transfer of 8'hC3 is correct.
